// File: rtl/enoc_node_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : enoc_node_interface (with enoc_ni_pkg, enoc_ni_fifo)          |
// | Brief    : Endpoint <-> network port adapter with injection/ejection     |
// |            FIFOs. Optional ENOC_NI_STATS_EN adds packet counters.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

package enoc_ni_pkg;
    typedef logic [31:0] packet_t;
endpackage

module enoc_ni_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push_val,
    input  logic [W-1:0] i_push_data,
    output logic         o_push_rdy,
    output logic         o_pop_val,
    output logic [W-1:0] o_pop_data,
    input  logic         i_pop_en
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Ready/valid come only from the registered count: no same-cycle bypass.
    assign o_push_rdy = (r_count != C_FULL);
    assign o_pop_val  = (r_count != '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push_val & o_push_rdy;
    assign w_pop      = i_pop_en & o_pop_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module enoc_node_interface
    import enoc_ni_pkg::*;
#(
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  packet_t     i_src_data,
    input  logic        i_src_val,
    output logic        o_src_rdy,
    output packet_t     o_net_data,
    output logic        o_net_val,
    input  logic        i_net_en,
    input  packet_t     i_net_data,
    input  logic        i_net_val,
    output logic        o_net_en,
    output packet_t     o_snk_data,
    output logic        o_snk_val,
    input  logic        i_snk_rdy
`ifdef ENOC_NI_STATS_EN
    ,
    output logic [31:0] o_inj_count,
    output logic [31:0] o_ej_count
`endif
);
    localparam int C_PW = $bits(packet_t);

    enoc_ni_fifo #(.DEPTH(INJ_DEPTH), .W(C_PW)) u_inj_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push_val  (i_src_val),
        .i_push_data (i_src_data),
        .o_push_rdy  (o_src_rdy),
        .o_pop_val   (o_net_val),
        .o_pop_data  (o_net_data),
        .i_pop_en    (i_net_en)
    );

    enoc_ni_fifo #(.DEPTH(EJ_DEPTH), .W(C_PW)) u_ej_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push_val  (i_net_val),
        .i_push_data (i_net_data),
        .o_push_rdy  (o_net_en),
        .o_pop_val   (o_snk_val),
        .o_pop_data  (o_snk_data),
        .i_pop_en    (i_snk_rdy)
    );

`ifdef ENOC_NI_STATS_EN
    logic [31:0] r_inj_count;
    logic [31:0] r_ej_count;

    // Free-running counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inj_count <= '0;
            r_ej_count  <= '0;
        end else begin
            if (o_net_val & i_net_en) begin
                r_inj_count <= r_inj_count + 32'd1;
            end
            if (o_snk_val & i_snk_rdy) begin
                r_ej_count <= r_ej_count + 32'd1;
            end
        end
    end

    assign o_inj_count = r_inj_count;
    assign o_ej_count  = r_ej_count;
`endif
endmodule

`default_nettype wire

// File: tb/tb_enoc_node_interface.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_enoc_node_interface                                        |
// | Brief    : Queue-model scoreboard bench for enoc_node_interface.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_enoc_node_interface;
    import enoc_ni_pkg::*;

    localparam int INJ_DEPTH = 4;
    localparam int EJ_DEPTH  = 4;

    logic    clk = 1'b0;
    logic    reset_n;
    packet_t src_data, net_data_in;
    logic    src_val, net_en_in, net_val_in, snk_rdy;
    packet_t o_net_data, o_snk_data;
    logic    o_src_rdy, o_net_val, o_net_en, o_snk_val;
`ifdef ENOC_NI_STATS_EN
    logic [31:0] o_inj_count, o_ej_count;
`endif

    enoc_node_interface #(.INJ_DEPTH(INJ_DEPTH), .EJ_DEPTH(EJ_DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_src_data  (src_data),
        .i_src_val   (src_val),
        .o_src_rdy   (o_src_rdy),
        .o_net_data  (o_net_data),
        .o_net_val   (o_net_val),
        .i_net_en    (net_en_in),
        .i_net_data  (net_data_in),
        .i_net_val   (net_val_in),
        .o_net_en    (o_net_en),
        .o_snk_data  (o_snk_data),
        .o_snk_val   (o_snk_val),
        .i_snk_rdy   (snk_rdy)
`ifdef ENOC_NI_STATS_EN
        ,
        .o_inj_count (o_inj_count),
        .o_ej_count  (o_ej_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: two packet queues plus transfer counters.
    packet_t     inj_q[$];
    packet_t     ej_q[$];
    bit          src_acc, net_acc;
    int          src_accs = 0, inj_pops = 0;
    logic [31:0] exp_inj_cnt = 0, exp_ej_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1ns before each rising edge, compares, then advances the model.
    always begin
        bit e_rdy, e_nval, e_en, e_sval, inj_pop, snk_pop;
        @(negedge clk);
        #4;
        if (reset_n) begin
            e_rdy  = (inj_q.size() != INJ_DEPTH);
            e_nval = (inj_q.size() != 0);
            e_en   = (ej_q.size() != EJ_DEPTH);
            e_sval = (ej_q.size() != 0);
            chk("src_rdy", o_src_rdy, e_rdy);
            chk("net_val", o_net_val, e_nval);
            chk("net_en", o_net_en, e_en);
            chk("snk_val", o_snk_val, e_sval);
            if (e_nval) chk("net_data", o_net_data, inj_q[0]);
            if (e_sval) chk("snk_data", o_snk_data, ej_q[0]);
`ifdef ENOC_NI_STATS_EN
            chk("inj_count", o_inj_count, exp_inj_cnt);
            chk("ej_count", o_ej_count, exp_ej_cnt);
`endif
            src_acc = src_val && e_rdy;
            inj_pop = e_nval && net_en_in;
            net_acc = net_val_in && e_en;
            snk_pop = e_sval && snk_rdy;
            if (inj_pop) begin
                void'(inj_q.pop_front());
                inj_pops++;
                exp_inj_cnt = exp_inj_cnt + 32'd1;
            end
            if (src_acc) begin
                inj_q.push_back(src_data);
                src_accs++;
            end
            if (snk_pop) begin
                void'(ej_q.pop_front());
                exp_ej_cnt = exp_ej_cnt + 32'd1;
            end
            if (net_acc) ej_q.push_back(net_data_in);
        end else begin
            src_acc = 1'b0;
            net_acc = 1'b0;
        end
    end

    task automatic drive(input bit sv, input bit ne, input bit nv, input bit sr);
        src_val     = sv;
        src_data    = $urandom;
        net_en_in   = ne;
        net_val_in  = nv;
        net_data_in = $urandom;
        snk_rdy     = sr;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_src_rdy"}, o_src_rdy, 1);
        chk({tag, "_net_val"}, o_net_val, 0);
        chk({tag, "_net_en"}, o_net_en, 1);
        chk({tag, "_snk_val"}, o_snk_val, 0);
        chk({tag, "_net_data"}, o_net_data, 0);
        chk({tag, "_snk_data"}, o_snk_data, 0);
`ifdef ENOC_NI_STATS_EN
        chk({tag, "_inj_count"}, o_inj_count, 0);
        chk({tag, "_ej_count"}, o_ej_count, 0);
`endif
    endtask

    initial begin
        int k, cyc, a0, p0;
        reset_n = 1'b0;
        src_val = 0; src_data = '0; net_en_in = 0; net_val_in = 0; net_data_in = '0; snk_rdy = 0;

        // 1: reset then idle
        #1;
        chk_reset_outputs("t1");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) drive(0, 0, 0, 0);

        // 2: fill injection FIFO with A..D, network disabled
        for (int i = 0; i < 4; i++) begin
            src_val = 1; src_data = 32'hA0 + i; net_en_in = 0; net_val_in = 0; snk_rdy = 0;
            @(negedge clk);
        end
        #1 chk("t2_full_rdy", o_src_rdy, 0);

        // 3: full FIFO, pop and push request together: only the pop happens
        src_val = 1; src_data = 32'hEE; net_en_in = 1;
        @(negedge clk);
        #1;
        chk("t3_rdy", o_src_rdy, 1);
        chk("t3_head", o_net_data, 32'hA1);
        repeat (5) drive(0, 1, 0, 0);

        // 4: network delivers P0..P5 while sink is stalled for 8 cycles
        k = 0; cyc = 0;
        while (k < 6 && cyc < 60) begin
            src_val = 0; net_en_in = 0;
            net_val_in = 1; net_data_in = 32'hB0 + k; snk_rdy = (cyc >= 8);
            @(negedge clk);
            if (net_acc) k++;
            cyc++;
            if (cyc == 5) begin
                #1 chk("t4_net_en_full", o_net_en, 0);
            end
        end
        chk("t4_all_delivered", k, 6);
        repeat (6) drive(0, 0, 0, 1);

        // 5: streaming, 100 packets at one per cycle
        a0 = src_accs; p0 = inj_pops;
        for (int i = 0; i < 101; i++) drive(i < 100, 1, 0, 0);
        chk("t5_accepted", src_accs - a0, 100);
        chk("t5_popped", inj_pops - p0, 100);

        // 6: asynchronous reset with packets buffered on both paths
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        inj_q.delete();
        ej_q.delete();
        exp_inj_cnt = 0;
        exp_ej_cnt  = 0;
        #1 chk_reset_outputs("t6");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) drive(0, 1, 0, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45);
        end

`ifdef ENOC_NI_STATS_EN
        // Counter wrap: preload all-ones, one injection pop wraps to zero
        repeat (8) drive(0, 1, 0, 1);
        drive(1, 0, 0, 1);
        force dut.r_inj_count = 32'hFFFF_FFFF;
        exp_inj_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_inj_count;
        drive(0, 1, 0, 1);
        #1 chk("stats_wrap", o_inj_count, 0);
        drive(0, 1, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
